// File: rtl/sysver_boot_reader.sv
// rtl/sysver_boot_reader.sv - APB master that reads the system version slave and holds decoded fields
module sysver_boot_reader #(
    parameter int                   ADDRWIDTH     = 16,
    parameter logic [ADDRWIDTH-1:0] C_BASE_ADDR   = '0,
    parameter int                   C_TIMEOUT     = 16,
    parameter logic [15:0]          C_EXPECT_TYPE = 16'h0000
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 start,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic [31:0]          pwdata,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr,
    output logic                 busy,
    output logic                 valid,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [1:0]           err_index,
    output logic [7:0]           ver_maj,
    output logic [7:0]           ver_min,
    output logic [31:0]          ver_build,
    output logic [15:0]          board_type,
    output logic [15:0]          board_rev,
    output logic                 board_match
);

    // Counter wide enough to hold C_TIMEOUT itself.
    localparam int TW = $clog2(C_TIMEOUT + 1);

    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic                   auto_q, auto_d;
    logic [1:0]             idx_q, idx_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [TW-1:0]          tcnt_inc;
    logic                   launch;

    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [1:0]             err_index_q, err_index_d;
    logic [7:0]             ver_maj_q, ver_maj_d;
    logic [7:0]             ver_min_q, ver_min_d;
    logic [31:0]            ver_build_q, ver_build_d;
    logic [15:0]            board_type_q, board_type_d;
    logic [15:0]            board_rev_q, board_rev_d;
    logic                   board_match_q, board_match_d;

    // Next-state and next-output computation for the read sequencer.
    always_comb begin
        state_d       = state_q;
        auto_d        = auto_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        tcnt_inc      = tcnt_q + TW'(1);
        launch        = 1'b0;
        paddr_d       = paddr_q;
        valid_d       = valid_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        err_index_d   = err_index_q;
        ver_maj_d     = ver_maj_q;
        ver_min_d     = ver_min_q;
        ver_build_d   = ver_build_q;
        board_type_d  = board_type_q;
        board_rev_d   = board_rev_q;
        board_match_d = board_match_q;

        case (state_q)
            S_IDLE: begin
                if (auto_q || start) begin
                    launch = 1'b1;
                    auto_d = 1'b0;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    launch = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        state_d     = S_ERROR;
                        err_d       = 1'b1;
                        valid_d     = 1'b0;
                        err_code_d  = ERR_SLAVE;
                        err_index_d = idx_q;
                    end else begin
                        case (idx_q)
                            2'd0: begin
                                ver_maj_d = prdata[15:8];
                                ver_min_d = prdata[7:0];
                            end
                            2'd1: begin
                                ver_build_d = prdata;
                            end
                            default: begin
                                board_type_d = prdata[31:16];
                                board_rev_d  = prdata[15:0];
                            end
                        endcase
                        if (idx_q >= 2'd2) begin
                            state_d       = S_DONE;
                            valid_d       = 1'b1;
                            board_match_d = (prdata[31:16] == C_EXPECT_TYPE);
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = S_SETUP;
                        end
                    end
                end else if (tcnt_inc == TW'(C_TIMEOUT)) begin
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                    valid_d     = 1'b0;
                    err_code_d  = ERR_TIMEOUT;
                    err_index_d = idx_q;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new sequence always begins at read 0 with status cleared; data fields persist.
        if (launch) begin
            state_d       = S_SETUP;
            idx_d         = 2'd0;
            valid_d       = 1'b0;
            err_d         = 1'b0;
            err_code_d    = 2'b00;
            err_index_d   = 2'b00;
            board_match_d = 1'b0;
        end

        // SETUP lasts one cycle, so landing there is always a SETUP entry.
        if (state_d == S_SETUP) begin
            tcnt_d  = '0;
            paddr_d = C_BASE_ADDR + ADDRWIDTH'({idx_d, 2'b00});
        end

        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        busy_d    = psel_d;
    end

    // State, counters and registered outputs; reset drops the bus immediately.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= S_IDLE;
            auto_q        <= 1'b1;
            idx_q         <= 2'd0;
            tcnt_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
            err_index_q   <= 2'b00;
            ver_maj_q     <= 8'h00;
            ver_min_q     <= 8'h00;
            ver_build_q   <= 32'h0;
            board_type_q  <= 16'h0;
            board_rev_q   <= 16'h0;
            board_match_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            auto_q        <= auto_d;
            idx_q         <= idx_d;
            tcnt_q        <= tcnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_index_q   <= err_index_d;
            ver_maj_q     <= ver_maj_d;
            ver_min_q     <= ver_min_d;
            ver_build_q   <= ver_build_d;
            board_type_q  <= board_type_d;
            board_rev_q   <= board_rev_d;
            board_match_q <= board_match_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = 1'b0;
    assign paddr       = paddr_q;
    assign pwdata      = 32'h0;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign err_index   = err_index_q;
    assign ver_maj     = ver_maj_q;
    assign ver_min     = ver_min_q;
    assign ver_build   = ver_build_q;
    assign board_type  = board_type_q;
    assign board_rev   = board_rev_q;
    assign board_match = board_match_q;

endmodule
